// File: rtl/program_run_sequencer_if.sv
// Bus bundle between the program/run sequencer and its host, memory port and CPU.
// The sequencer connects through the slave modport; the host side uses master.
interface program_run_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 32
) ();
    logic              load_req;
    logic [ADDR_W-1:0] load_len;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              run_req;
    logic [ADDR_W-1:0] stop_addr;
    logic [CNT_W-1:0]  max_cycles;
    logic              abort;
    logic [ADDR_W-1:0] cpu_pc;
    logic              cpu_rst;
    logic              cpu_start;
    logic              busy;
    logic              load_done;
    logic              run_done;
    logic [1:0]        run_status;
    logic [CNT_W-1:0]  cycle_count;

    modport slave (
        input  load_req, load_len, in_data, in_valid, run_req, stop_addr,
               max_cycles, abort, cpu_pc,
        output in_ready, mem_addr, mem_wdata, mem_we, cpu_rst, cpu_start,
               busy, load_done, run_done, run_status, cycle_count
    );

    modport master (
        output load_req, load_len, in_data, in_valid, run_req, stop_addr,
               max_cycles, abort, cpu_pc,
        input  in_ready, mem_addr, mem_wdata, mem_we, cpu_rst, cpu_start,
               busy, load_done, run_done, run_status, cycle_count
    );
endinterface

// File: rtl/program_run_sequencer.sv
// Loads a program image into shared memory with the CPU held in reset, then
// releases the CPU, issues the start handshake and supervises the run.
module program_run_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    program_run_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, LOAD, RELEASE, START_HI, START_LO, RUN, FINISH
    } state_t;

    typedef enum logic [1:0] {
        ST_NONE    = 2'b00,
        ST_HIT     = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_ABORT   = 2'b11
    } status_t;

    state_t            state, state_nx;
    status_t           status_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] stop_q;
    logic [CNT_W-1:0]  max_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              load_done_q;

    logic accept, last_word, stop_hit, timeout;

    always_comb begin
        accept    = (state == LOAD) && bus.in_valid;
        last_word = accept && (wr_ptr == len_q - ADDR_W'(1));
        stop_hit  = (state == RUN) && (bus.cpu_pc == stop_q);
        timeout   = (state == RUN) && (max_q != '0) && (cnt_q == max_q - CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.load_req) begin
                    if (bus.load_len != '0) state_nx = LOAD;
                end else if (bus.run_req) begin
                    state_nx = RELEASE;
                end
            end
            LOAD:     if (bus.abort) state_nx = FINISH;
                      else if (last_word) state_nx = IDLE;
            RELEASE:  state_nx = bus.abort ? FINISH : START_HI;
            START_HI: state_nx = bus.abort ? FINISH : START_LO;
            START_LO: state_nx = bus.abort ? FINISH : RUN;
            RUN:      if (bus.abort || stop_hit || timeout) state_nx = FINISH;
            FINISH:   state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Abort outranks a stop hit, which outranks a timeout in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q    <= ST_NONE;
            len_q       <= '0;
            wr_ptr      <= '0;
            stop_q      <= '0;
            max_q       <= '0;
            cnt_q       <= '0;
            load_done_q <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load_req) begin
                        if (bus.load_len == '0) begin
                            load_done_q <= 1'b1;
                        end else begin
                            len_q  <= bus.load_len;
                            wr_ptr <= '0;
                        end
                    end else if (bus.run_req) begin
                        stop_q   <= bus.stop_addr;
                        max_q    <= bus.max_cycles;
                        cnt_q    <= '0;
                        status_q <= ST_NONE;
                    end
                end
                LOAD: begin
                    if (accept) wr_ptr <= wr_ptr + ADDR_W'(1);
                    if (bus.abort)      status_q    <= ST_ABORT;
                    else if (last_word) load_done_q <= 1'b1;
                end
                RELEASE, START_HI, START_LO: begin
                    if (bus.abort) status_q <= ST_ABORT;
                end
                RUN: begin
                    if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                    if (bus.abort)     status_q <= ST_ABORT;
                    else if (stop_hit) status_q <= ST_HIT;
                    else if (timeout)  status_q <= ST_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.in_ready    = (state == LOAD);
        bus.mem_we      = accept;
        bus.mem_addr    = wr_ptr;
        bus.mem_wdata   = (state == LOAD) ? bus.in_data : '0;
        bus.cpu_rst     = 1'b1;
        bus.cpu_start   = (state == START_HI);
        bus.busy        = (state != IDLE);
        bus.load_done   = load_done_q;
        bus.run_done    = (state == FINISH);
        bus.run_status  = status_q;
        bus.cycle_count = cnt_q;
        case (state)
            RELEASE, START_HI, START_LO, RUN: bus.cpu_rst = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_program_run_sequencer.sv
// Randomized self-checking bench for program_run_sequencer; expectations come
// from a transaction-level model of load and run outcomes.
module tb_program_run_sequencer;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [DATA_W-1:0] prog [0:63];

    program_run_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    program_run_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.load_req   = 1'b0;
        bus.load_len   = '0;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.run_req    = 1'b0;
        bus.stop_addr  = '0;
        bus.max_cycles = '0;
        bus.abort      = 1'b0;
        bus.cpu_pc     = '0;
    endtask

    // Stream n words of prog[]; valid comes from pat bits or is random.
    task automatic do_load(input int n, input bit rnd, input logic [31:0] pat);
        int acc = 0;
        int cyc = 0;
        bit v;
        @(negedge clk);
        bus.load_req = 1'b1;
        bus.load_len = ADDR_W'(n);
        bus.in_valid = 1'b0;
        while (acc < n && cyc < n * 8 + 64) begin
            @(negedge clk);
            bus.load_req = 1'b0;
            v = rnd ? 1'($urandom % 2) : ((cyc < 32) ? pat[cyc] : 1'b1);
            bus.in_valid = v;
            bus.in_data  = v ? prog[acc] : 8'($urandom);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1 || bus.load_done !== 1'b0 || bus.cpu_rst !== 1'b1) begin
                errors++;
                $display("FAIL load_state: ready=%b busy=%b load_done=%b cpu_rst=%b, required 1 1 0 1", bus.in_ready, bus.busy, bus.load_done, bus.cpu_rst);
            end
            checks++;
            if (bus.mem_we !== v || bus.mem_addr !== ADDR_W'(acc)) begin
                errors++;
                $display("FAIL load_write: we=%b addr=%0d, required we=%b addr=%0d", bus.mem_we, bus.mem_addr, v, acc);
            end
            if (v) begin
                checks++;
                if (bus.mem_wdata !== prog[acc]) begin
                    errors++;
                    $display("FAIL load_data: addr %0d wdata=%h, required %h", acc, bus.mem_wdata, prog[acc]);
                end
                acc++;
            end
            cyc++;
        end
        checks++;
        if (acc < n) begin
            errors++;
            $display("FAIL load_bound: accepted %0d words, required %0d", acc, n);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.load_done !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.mem_we !== 1'b0 ||
            bus.mem_addr !== ADDR_W'(n) || bus.mem_wdata !== '0) begin
            errors++;
            $display("FAIL load_end: done=%b ready=%b busy=%b we=%b addr=%0d wdata=%h, required 1 0 0 0 %0d 00",
                     bus.load_done, bus.in_ready, bus.busy, bus.mem_we, bus.mem_addr, bus.mem_wdata, n);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.load_done !== 1'b0) begin
            errors++;
            $display("FAIL load_done_pulse: load_done=%b, required 0", bus.load_done);
        end
    endtask

    // Run model: run ends in the first RUN cycle k with abort, pc hit or k==max.
    task automatic do_run(input logic [ADDR_W-1:0] stop, input logic [CNT_W-1:0] maxc,
                          input int abort_at, input bit rnd_pc);
        int k = 0;
        bit ended = 1'b0;
        logic [1:0] exp_st = 2'b00;
        logic [ADDR_W-1:0] pcv;
        @(negedge clk);
        bus.run_req    = 1'b1;
        bus.stop_addr  = stop;
        bus.max_cycles = maxc;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL run_idle: busy=%b cpu_rst=%b, required 0 1", bus.busy, bus.cpu_rst);
        end
        @(negedge clk);
        bus.run_req    = 1'b0;
        bus.stop_addr  = ADDR_W'($urandom);
        bus.max_cycles = $urandom;
        #1;
        checks++;
        if ({bus.cpu_rst, bus.cpu_start, bus.busy} !== 3'b001 || bus.run_status !== 2'b00 || bus.cycle_count !== '0) begin
            errors++;
            $display("FAIL release: rst/start/busy=%b status=%b count=%0d, required 001 00 0",
                     {bus.cpu_rst, bus.cpu_start, bus.busy}, bus.run_status, bus.cycle_count);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.cpu_rst, bus.cpu_start} !== 2'b01) begin
            errors++;
            $display("FAIL start_hi: rst/start=%b, required 01", {bus.cpu_rst, bus.cpu_start});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.cpu_rst, bus.cpu_start} !== 2'b00) begin
            errors++;
            $display("FAIL start_lo: rst/start=%b, required 00", {bus.cpu_rst, bus.cpu_start});
        end
        while (!ended && k < 200) begin
            k++;
            @(negedge clk);
            pcv = rnd_pc ? ADDR_W'($urandom_range(0, 15)) : ADDR_W'(k - 1);
            bus.cpu_pc = pcv;
            bus.abort  = (k == abort_at);
            #1;
            checks++;
            if (bus.cpu_rst !== 1'b0 || bus.cpu_start !== 1'b0 || bus.run_done !== 1'b0 || bus.cycle_count !== CNT_W'(k - 1)) begin
                errors++;
                $display("FAIL run_cycle %0d: rst=%b start=%b done=%b count=%0d, required 0 0 0 %0d",
                         k, bus.cpu_rst, bus.cpu_start, bus.run_done, bus.cycle_count, k - 1);
            end
            if (k == abort_at) begin
                exp_st = 2'b11; ended = 1'b1;
            end else if (pcv == stop) begin
                exp_st = 2'b01; ended = 1'b1;
            end else if (maxc != '0 && CNT_W'(k) == maxc) begin
                exp_st = 2'b10; ended = 1'b1;
            end
        end
        checks++;
        if (!ended) begin
            errors++;
            $display("FAIL run_bound: run not ended after %0d cycles, required an end", k);
        end
        @(negedge clk);
        bus.abort  = 1'b0;
        bus.cpu_pc = ADDR_W'($urandom);
        #1;
        checks++;
        if (bus.run_done !== 1'b1 || bus.cpu_rst !== 1'b1 || bus.run_status !== exp_st || bus.cycle_count !== CNT_W'(k)) begin
            errors++;
            $display("FAIL finish: done=%b cpu_rst=%b status=%b count=%0d, required 1 1 %b %0d",
                     bus.run_done, bus.cpu_rst, bus.run_status, bus.cycle_count, exp_st, k);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.run_done !== 1'b0 || bus.busy !== 1'b0 || bus.cpu_rst !== 1'b1 ||
            bus.run_status !== exp_st || bus.cycle_count !== CNT_W'(k)) begin
            errors++;
            $display("FAIL after_run: done=%b busy=%b cpu_rst=%b status=%b count=%0d, required 0 0 1 %b %0d",
                     bus.run_done, bus.busy, bus.cpu_rst, bus.run_status, bus.cycle_count, exp_st, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.cpu_rst, bus.cpu_start, bus.mem_we, bus.in_ready, bus.busy, bus.load_done, bus.run_done} !== 7'b1000000 ||
            bus.run_status !== 2'b00 || bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.cycle_count !== '0) begin
            errors++;
            $display("FAIL reset: flags=%b status=%b addr=%0d wdata=%h count=%0d, required 1000000 00 0 00 0",
                     {bus.cpu_rst, bus.cpu_start, bus.mem_we, bus.in_ready, bus.busy, bus.load_done, bus.run_done},
                     bus.run_status, bus.mem_addr, bus.mem_wdata, bus.cycle_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_basic();
        prog[0] = 8'hA1; prog[1] = 8'hB2; prog[2] = 8'hC3; prog[3] = 8'hD4;
        do_load(4, 1'b0, '1);
    endtask

    task automatic test_load_gaps();
        for (int i = 0; i < 3; i++) prog[i] = 8'($urandom);
        do_load(3, 1'b0, 32'h0000_0029);
    endtask

    task automatic test_runs();
        do_run(ADDR_W'(5), '0, 0, 1'b0);
        do_run('1, CNT_W'(10), 0, 1'b0);
        do_run('1, '0, 3, 1'b0);
        do_run(ADDR_W'(2), '0, 0, 1'b0);
        do_run('0, CNT_W'(5), 0, 1'b0);
        do_run(ADDR_W'(3), CNT_W'(4), 0, 1'b0);
        do_run('1, CNT_W'(1), 0, 1'b0);
    endtask

    task automatic test_priority_zero_len();
        @(negedge clk);
        bus.load_req = 1'b1;
        bus.load_len = '0;
        bus.run_req  = 1'b1;
        bus.stop_addr = '0;
        @(negedge clk);
        bus.load_req = 1'b0;
        bus.run_req  = 1'b0;
        #1;
        checks++;
        if (bus.load_done !== 1'b1 || bus.busy !== 1'b0 || bus.cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL zero_len: load_done=%b busy=%b cpu_rst=%b, required 1 0 1", bus.load_done, bus.busy, bus.cpu_rst);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.load_done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_after: load_done=%b busy=%b, required 0 0", bus.load_done, bus.busy);
        end
    endtask

    task automatic test_abort_load();
        @(negedge clk);
        bus.load_req = 1'b1;
        bus.load_len = ADDR_W'(4);
        @(negedge clk);
        bus.load_req = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.abort    = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.mem_addr !== ADDR_W'(1)) begin
            errors++;
            $display("FAIL abort_load_pre: ready=%b addr=%0d, required 1 1", bus.in_ready, bus.mem_addr);
        end
        @(negedge clk);
        bus.abort = 1'b0;
        #1;
        checks++;
        if (bus.run_done !== 1'b1 || bus.run_status !== 2'b11 || bus.load_done !== 1'b0 ||
            bus.cpu_rst !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_load: done=%b status=%b load_done=%b cpu_rst=%b ready=%b, required 1 11 0 1 0",
                     bus.run_done, bus.run_status, bus.load_done, bus.cpu_rst, bus.in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.run_done !== 1'b0 || bus.load_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_load_idle: busy=%b done=%b load_done=%b, required 0 0 0", bus.busy, bus.run_done, bus.load_done);
        end
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 5; i++) prog[i] = 8'($urandom);
        @(negedge clk);
        bus.load_req = 1'b1;
        bus.load_len = ADDR_W'(5);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.load_req = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = prog[i];
        end
        @(negedge clk);
        rst = 1'b1;
        bus.in_data = prog[2];
        @(negedge clk);
        #1;
        checks++;
        if ({bus.cpu_rst, bus.cpu_start, bus.mem_we, bus.in_ready, bus.busy, bus.load_done, bus.run_done} !== 7'b1000000 ||
            bus.run_status !== 2'b00 || bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.cycle_count !== '0) begin
            errors++;
            $display("FAIL reset_mid_load: flags=%b status=%b addr=%0d wdata=%h count=%0d, required 1000000 00 0 00 0",
                     {bus.cpu_rst, bus.cpu_start, bus.mem_we, bus.in_ready, bus.busy, bus.load_done, bus.run_done},
                     bus.run_status, bus.mem_addr, bus.mem_wdata, bus.cycle_count);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.load_done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: load_done=%b busy=%b, required 0 0", bus.load_done, bus.busy);
        end
        for (int i = 0; i < 3; i++) prog[i] = 8'($urandom);
        do_load(3, 1'b0, '1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 15; it++) begin
            int n;
            int mc;
            int ab;
            n = int'($urandom_range(1, 40));
            for (int i = 0; i < n; i++) prog[i] = 8'($urandom);
            do_load(n, 1'b1, '0);
            mc = int'($urandom_range(0, 20));
            if (mc == 0)                ab = int'($urandom_range(1, 40));
            else if ($urandom % 4 == 0) ab = int'($urandom_range(1, 25));
            else                        ab = 0;
            do_run(ADDR_W'($urandom_range(0, 15)), CNT_W'(mc), ab, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_load_gaps();
        test_runs();
        test_priority_zero_len();
        test_abort_load();
        test_reset_mid_load();
        do_run(ADDR_W'(1), '0, 0, 1'b0);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/program_run_sequencer.md
Name: program_run_sequencer

Overview:
Upstream sequencer for the multi-cycle accumulator CPU. It streams a program image into the shared instruction/data memory while the CPU is held in reset. It then releases the CPU and produces the controller's start handshake: start high for one cycle, then low. The run ends on a stop-address match or a cycle-budget timeout, after which the CPU is re-held and a status is reported.

Parameters:
DATA_W, 8, memory word width.
ADDR_W, 12, memory address / PC width.
CNT_W, 32, width of the run cycle counter and budget.

Ports:
clk  in  1  system clock, single domain.
rst  in  1  synchronous, active-high reset.
load_req  in  1  one-cycle request: load load_len words starting at address 0.
load_len  in  ADDR_W  number of words to load; sampled with load_req.
in_data  in  DATA_W  program word stream.
in_valid  in  1  in_data valid.
in_ready  out  1  sequencer accepts a word.
mem_addr  out  ADDR_W  memory write address.
mem_wdata  out  DATA_W  memory write data.
mem_we  out  1  memory write enable.
run_req  in  1  one-cycle request to execute the loaded program.
stop_addr  in  ADDR_W  PC value that ends the run; sampled with run_req.
max_cycles  in  CNT_W  run budget in clocks, 0 = unlimited; sampled with run_req.
abort  in  1  cancels a load or run in progress.
cpu_pc  in  ADDR_W  current CPU program counter.
cpu_rst  out  1  CPU/controller reset; the controller is held in IDLE while high.
cpu_start  out  1  controller start input.
busy  out  1  high in any state other than IDLE.
load_done  out  1  one-cycle pulse when a load completes.
run_done  out  1  one-cycle pulse when a run ends.
run_status  out  2  outcome of the last run: 00 none, 01 stop-address hit, 10 timeout, 11 aborted.
cycle_count  out  CNT_W  clocks spent in RUN during the last or current run.

Behaviour:
- Reset values: cpu_rst=1, cpu_start=0, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, busy=0, load_done=0, run_done=0, run_status=00, cycle_count=0, state=IDLE.
- A reset asserted in any state returns the block to these values on the next edge. A load in progress is lost; memory contents already written are not cleared.
- States: IDLE, LOAD, RELEASE, START_HI, START_LO, RUN, FINISH.
- IDLE:
  - cpu_rst=1, in_ready=0.
  - load_req with load_len>0: capture len, clear wr_ptr, go to LOAD.
  - load_req with load_len=0: pulse load_done next cycle, stay IDLE.
  - run_req (ignored if load_req is also high; load_req wins): capture stop_addr and max_cycles, clear cycle_count, set run_status=00, go to RELEASE.
  - run_req and load_req are ignored in all other states.
- LOAD:
  - in_ready=1, cpu_rst=1.
  - Memory interface is combinational: mem_we = in_valid & in_ready; mem_addr = wr_ptr; mem_wdata = in_data.
  - Each accepted word increments wr_ptr.
  - On acceptance of word len-1: go to IDLE and pulse load_done for one cycle. in_ready drops in that IDLE cycle.
  - Outside LOAD: mem_we=0 and mem_wdata=0; mem_addr holds wr_ptr.
  - wr_ptr wraps modulo 2^ADDR_W. A len above 2^ADDR_W is impossible by width.
- RELEASE: cpu_rst=0, cpu_start=0 for exactly one cycle, letting the controller leave reset in IDLE with start low.
- START_HI: cpu_start=1 for exactly one cycle; the controller moves IDLE->START.
- START_LO: cpu_start=0 for one cycle; the controller moves START->FETCH. Go to RUN.
- RUN:
  - cpu_rst=0, cpu_start=0; cycle_count increments by 1 every RUN cycle, saturating at all-ones.
  - Stop-address hit: cpu_pc==stop_addr in a RUN cycle sets run_status=01 and goes to FINISH. stop_addr=0 therefore ends the run in the first RUN cycle.
  - Timeout: max_cycles!=0 and cycle_count==max_cycles-1 in a RUN cycle with no stop-address hit sets run_status=10 and goes to FINISH. The reported cycle_count is then max_cycles.
  - A stop-address hit and timeout in the same cycle report 01.
- FINISH: cpu_rst=1, run_done=1 for one cycle, then IDLE. cycle_count and run_status hold until the next run_req.
- Abort:
  - In LOAD, RELEASE, START_HI, START_LO or RUN, abort goes to FINISH with run_status=11. run_done pulses even for an aborted load.
  - load_done is not pulsed on abort.
  - Abort in IDLE or FINISH is ignored.
  - abort has priority over a stop-address hit or timeout in the same cycle.
- Run-request-to-first-RUN-cycle latency is 4 clocks: IDLE -> RELEASE -> START_HI -> START_LO -> RUN.

Test Plan:
- Reset, then load_req with load_len=4 and words A1,B2,C3,D4 with in_valid held high -> mem_we high 4 cycles at addresses 0..3 with matching data; load_done pulses once; in_ready low afterwards.
- Load of 3 words with in_valid gaps (1,0,0,1,0,1) -> exactly 3 writes at 0,1,2; no write in gap cycles; load_done after the third accept.
- run_req with stop_addr=5, max_cycles=0, and cpu_pc driven 0,1,2,3,4,5 from the first RUN cycle -> cpu_rst low from RELEASE; cpu_start high only in START_HI; run_status=01; cycle_count=6; single run_done pulse; cpu_rst high again.
- run_req with stop_addr=FFF and max_cycles=10 while the PC never matches -> run_status=10, cycle_count=10, run_done after the 10th RUN cycle.
- abort in the 3rd RUN cycle -> FINISH next, run_status=11, cpu_rst=1; a subsequent run_req is accepted normally.
- rst asserted in the middle of LOAD after 2 of 5 words -> all outputs at reset values next cycle, in_ready=0, no load_done; a later load restarts at address 0.
